// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the 4-bit ALU command path.
//   Opcode constants (8-bit, as driven on the ALU select input), the
//   sequencer FSM state type and the forced divide-by-zero result.
//   No ports.
package alu_pkg;

   localparam logic [7:0] OP_ADD = 8'd0;
   localparam logic [7:0] OP_SUB = 8'd1;
   localparam logic [7:0] OP_MUL = 8'd2;
   localparam logic [7:0] OP_DIV = 8'd3;
   localparam logic [7:0] OP_AND = 8'd4;

   localparam logic [7:0] DIV0_RESULT = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OPND  = 2'd1,
      ISSUE = 2'd2,
      WAIT  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if -- switch-bus / ALU / display bundle of the command
// sequencer.
//   din, din_strobe     : switch bus and its asynchronous load strobe
//   alu_operands        : {B[3:0], A[3:0]} to the ALU
//   alu_opcode          : ALU select
//   alu_result          : registered ALU result back to the sequencer
//   result, result_valid: captured result for the display path
//   busy                : command in flight to the ALU
//   div0_err            : only with ALU_SEQ_DIV0_CHECK_EN
// Modports: slave = sequencer side, master = upstream/environment side.
interface alu_cmd_sequencer_if;

   logic [7:0] din;
   logic       din_strobe;
   logic [7:0] alu_operands;
   logic [7:0] alu_opcode;
   logic [7:0] alu_result;
   logic [7:0] result;
   logic       result_valid;
   logic       busy;
`ifdef ALU_SEQ_DIV0_CHECK_EN
   logic       div0_err;
`endif

   modport slave (
      input  din, din_strobe, alu_result,
      output alu_operands, alu_opcode, result, result_valid, busy
`ifdef ALU_SEQ_DIV0_CHECK_EN
      , output div0_err
`endif
   );

   modport master (
      output din, din_strobe, alu_result,
      input  alu_operands, alu_opcode, result, result_valid, busy
`ifdef ALU_SEQ_DIV0_CHECK_EN
      , input div0_err
`endif
   );

endinterface

// File: rtl/alu_cmd_sequencer_strobe_sync.sv
// strobe_sync -- synchronizer plus rising-edge detector for a slow pin strobe.
//   clk, rst : clock, asynchronous active-high reset
//   strobe   : asynchronous pin input
//   load     : one-cycle pulse per rising edge of the synchronized strobe
// Parameter SYNC_STAGES (>= 2) sets the synchronizer depth.
module strobe_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic strobe,
   output logic load
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   // Fills with ones after reset. The detector is armed only once both the
   // synchronizer output and its delayed copy hold real pin samples, so a
   // strobe held high through reset release never looks like an edge.
   logic [SYNC_STAGES:0]   vld_pipe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q   <= '0;
         prev_q   <= 1'b0;
         vld_pipe <= '0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], strobe};
         prev_q   <= sync_q[SYNC_STAGES-1];
         vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign load = vld_pipe[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer -- collects {operand byte, opcode byte} from the switch
// bus on strobe edges, holds them on the ALU inputs for one registered ALU
// evaluation, then captures the ALU result for display.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : alu_cmd_sequencer_if.slave (see interface header)
// Parameter SYNC_STAGES: strobe synchronizer depth (>= 2).
// Macro ALU_SEQ_DIV0_CHECK_EN: divide by a zero B operand is answered
// locally with DIV0_RESULT and div0_err, without issuing to the ALU.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input logic                clk,
   input logic                rst,
   alu_cmd_sequencer_if.slave bus
);

   logic       load;
   seq_state_t state;
   logic [7:0] operands_q;
   logic [7:0] opcode_q;
   logic [7:0] result_q;
   logic       valid_q;
   logic       busy_q;
`ifdef ALU_SEQ_DIV0_CHECK_EN
   logic       div0_q;
`endif

   strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_sync (
      .clk    (clk),
      .rst    (rst),
      .strobe (bus.din_strobe),
      .load   (load)
   );

   // A load arriving in ISSUE or WAIT is simply not looked at.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         operands_q <= '0;
         opcode_q   <= '0;
         result_q   <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
`ifdef ALU_SEQ_DIV0_CHECK_EN
         div0_q     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  operands_q <= bus.din;
                  valid_q    <= 1'b0;
`ifdef ALU_SEQ_DIV0_CHECK_EN
                  div0_q     <= 1'b0;
`endif
                  state      <= OPND;
               end
            end
            OPND: begin
               if (load) begin
                  opcode_q <= bus.din;
`ifdef ALU_SEQ_DIV0_CHECK_EN
                  if (bus.din == OP_DIV && operands_q[7:4] == 4'h0) begin
                     result_q <= DIV0_RESULT;
                     valid_q  <= 1'b1;
                     div0_q   <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     busy_q <= 1'b1;
                     state  <= ISSUE;
                  end
`else
                  busy_q   <= 1'b1;
                  state    <= ISSUE;
`endif
               end
            end
            // ALU registers its inputs at the end of this cycle.
            ISSUE: state <= WAIT;
            WAIT: begin
               result_q <= bus.alu_result;
               valid_q  <= 1'b1;
               busy_q   <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.alu_operands = operands_q;
   assign bus.alu_opcode   = opcode_q;
   assign bus.result       = result_q;
   assign bus.result_valid = valid_q;
   assign bus.busy         = busy_q;
`ifdef ALU_SEQ_DIV0_CHECK_EN
   assign bus.div0_err     = div0_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer -- bench for alu_cmd_sequencer: environment ALU,
// edge-indexed behavioural model, per-cycle compare, directed literal checks
// and randomized command traffic. Honours ALU_SEQ_DIV0_CHECK_EN.
module tb_alu_cmd_sequencer;
   import alu_pkg::*;

   localparam int N = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_cmd_sequencer_if bus();

   alu_cmd_sequencer #(.SYNC_STAGES(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int fails  = 0;
   int busy_cycles = 0;

   // Reference 4-bit ALU: A = operands[3:0], B = operands[7:4].
   function automatic logic [7:0] alu_ref(input logic [7:0] opnd, input logic [7:0] opc);
      logic [7:0] a, b;
      a = {4'h0, opnd[3:0]};
      b = {4'h0, opnd[7:4]};
      case (opc)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_MUL:  return a * b;
         OP_DIV:  return (b == 8'h00) ? 8'hEE : a / b;
         OP_AND:  return a & b;
         default: return opnd;
      endcase
   endfunction

   // Environment ALU with its registered output.
   always @(posedge clk) bus.alu_result <= alu_ref(bus.alu_operands, bus.alu_opcode);

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Edges are numbered from 1 after reset; samp[i-1] is the strobe level
   // seen at edge i. A rise first seen at edge k takes effect at edge k+N.
   // An opcode accepted at edge E occupies the ALU through edge E+2, where
   // the result is captured; loads at E+1 and E+2 are lost.
   logic [7:0] m_opnd, m_opc, m_res;
   logic       m_valid, m_busy, m_div0;
   bit         m_second, m_pend;
   int         ec, e_issue;
   bit         samp[$];

   task automatic model_clear();
      m_opnd = '0; m_opc = '0; m_res = '0;
      m_valid = 1'b0; m_busy = 1'b0; m_div0 = 1'b0;
      m_second = 1'b0; m_pend = 1'b0;
      ec = 0; e_issue = 0;
      samp.delete();
   endtask

   task automatic model_step();
      bit ld;
      ec++;
      samp.push_back(bus.din_strobe);
      ld = (ec - N - 1 >= 1) && samp[ec-N-1] && !samp[ec-N-2];
      if (m_pend && ec == e_issue + 2) begin
         m_res   = alu_ref(m_opnd, m_opc);
         m_valid = 1'b1;
         m_pend  = 1'b0;
      end else if (ld && !m_pend) begin
         if (!m_second) begin
            m_opnd   = bus.din;
            m_valid  = 1'b0;
            m_div0   = 1'b0;
            m_second = 1'b1;
         end else begin
            m_opc    = bus.din;
            m_second = 1'b0;
`ifdef ALU_SEQ_DIV0_CHECK_EN
            if (bus.din == 8'd3 && m_opnd[7:4] == 4'h0) begin
               m_res   = 8'hFF;
               m_valid = 1'b1;
               m_div0  = 1'b1;
            end else begin
               m_pend  = 1'b1;
               e_issue = ec;
            end
`else
            m_pend  = 1'b1;
            e_issue = ec;
`endif
         end
      end
      m_busy = m_pend;
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_clear();
         else     model_step();
      end
   end

   // Per-cycle compare against the model.
   initial begin
      forever begin
         @(negedge clk);
         chk("cyc_operands", bus.alu_operands, m_opnd);
         chk("cyc_opcode",   bus.alu_opcode,   m_opc);
         chk("cyc_result",   bus.result,       m_res);
         chk("cyc_valid",    {7'b0, bus.result_valid}, {7'b0, m_valid});
         chk("cyc_busy",     {7'b0, bus.busy},         {7'b0, m_busy});
`ifdef ALU_SEQ_DIV0_CHECK_EN
         chk("cyc_div0",     {7'b0, bus.div0_err},     {7'b0, m_div0});
`endif
         if (bus.busy === 1'b1) busy_cycles++;
      end
   end

   // din held until at least N edges past the strobe rise.
   task automatic send(input logic [7:0] b, input int w, input int gap);
      @(negedge clk);
      bus.din = b;
      bus.din_strobe = 1'b1;
      repeat (w) @(negedge clk);
      bus.din_strobe = 1'b0;
      repeat (gap + N) @(negedge clk);
   endtask

   task automatic settle();
      repeat (6) @(negedge clk);
   endtask

   initial begin
      bus.din = 8'h00;
      bus.din_strobe = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_operands", bus.alu_operands, 8'h00);
      chk("rst_opcode",   bus.alu_opcode,   8'h00);
      chk("rst_result",   bus.result,       8'h00);
      chk("rst_valid",    {7'b0, bus.result_valid}, 8'h00);
      chk("rst_busy",     {7'b0, bus.busy},         8'h00);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Add with exact latency: opcode strobe high at negedge n.
      send(8'h53, 2, 0);
      busy_cycles = 0;
      @(negedge clk); bus.din = 8'h00; bus.din_strobe = 1'b1;
      @(negedge clk); bus.din_strobe = 1'b0;
      repeat (3) @(negedge clk);
      chk("add_valid_early", {7'b0, bus.result_valid}, 8'h00);
      @(negedge clk);
      chk("add_valid_n5", {7'b0, bus.result_valid}, 8'h01);
      chk("add_result",   bus.result,       8'h08);
      chk("add_operands", bus.alu_operands, 8'h53);
      chk("add_opcode",   bus.alu_opcode,   8'h00);
      settle();
      chk("add_busy_len", 8'(busy_cycles),  8'd2);

      // Multiply, then valid drops one cycle after the next first-byte load.
      send(8'hFF, 1, 0);
      send(8'h02, 2, 0);
      settle();
      chk("mul_result", bus.result, 8'hE1);
      @(negedge clk); bus.din = 8'h12; bus.din_strobe = 1'b1;
      @(negedge clk); bus.din_strobe = 1'b0;
      @(negedge clk);
      chk("next_valid_hold", {7'b0, bus.result_valid}, 8'h01);
      @(negedge clk);
      chk("next_valid_drop", {7'b0, bus.result_valid}, 8'h00);
      chk("next_result_held", bus.result, 8'hE1);
      send(8'h04, 1, 0);
      settle();
      chk("and_result", bus.result, 8'h00);

      // Strobe whose load falls while busy is dropped.
      send(8'h3C, 1, 0);
      @(negedge clk); bus.din = 8'h01; bus.din_strobe = 1'b1;
      @(negedge clk); bus.din_strobe = 1'b0;
      @(negedge clk); bus.din_strobe = 1'b1;
      @(negedge clk); bus.din = 8'h77;
      @(negedge clk); bus.din_strobe = 1'b0;
      settle();
      chk("drop_operands", bus.alu_operands, 8'h3C);
      chk("drop_opcode",   bus.alu_opcode,   8'h01);
      chk("drop_result",   bus.result,       8'h09);
      send(8'h21, 1, 0);
      chk("drop_idle_first", bus.alu_operands, 8'h21);
      send(8'h00, 1, 0);
      settle();
      chk("drop_next_result", bus.result, 8'h03);

      // Divide by zero.
      busy_cycles = 0;
      send(8'h07, 1, 0);
      send(8'h03, 1, 0);
      settle();
`ifdef ALU_SEQ_DIV0_CHECK_EN
      chk("div0_result", bus.result, 8'hFF);
      chk("div0_flag",   {7'b0, bus.div0_err}, 8'h01);
      chk("div0_busy",   8'(busy_cycles), 8'd0);
`else
      chk("div0_result", bus.result, 8'hEE);
      chk("div0_busy",   8'(busy_cycles), 8'd2);
`endif
      chk("div0_valid", {7'b0, bus.result_valid}, 8'h01);

      // Opcode above 4 forwarded.
      send(8'hA5, 1, 0);
      send(8'h09, 1, 0);
      settle();
      chk("dflt_opcode", bus.alu_opcode, 8'h09);
      chk("dflt_result", bus.result,     8'hA5);

      // Reset in WAIT, released with strobe held high.
      send(8'h34, 1, 0);
      @(negedge clk); bus.din = 8'h00; bus.din_strobe = 1'b1;
      @(negedge clk); bus.din_strobe = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_busy", {7'b0, bus.busy}, 8'h01);
      #2 rst = 1'b1;
      bus.din_strobe = 1'b1;
      #1;
      chk("mid_rst_operands", bus.alu_operands, 8'h00);
      chk("mid_rst_opcode",   bus.alu_opcode,   8'h00);
      chk("mid_rst_result",   bus.result,       8'h00);
      chk("mid_rst_valid",    {7'b0, bus.result_valid}, 8'h00);
      chk("mid_rst_busy",     {7'b0, bus.busy},         8'h00);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("held_no_load", bus.alu_operands, 8'h00);
      bus.din_strobe = 1'b0;
      repeat (2) @(negedge clk);
      send(8'h56, 1, 0);
      chk("rearm_load", bus.alu_operands, 8'h56);
      send(8'h00, 1, 0);
      settle();
      chk("rearm_result", bus.result, 8'h0B);

      // Randomized traffic.
      for (int i = 0; i < 120; i++) begin
         logic [7:0] op;
         op = 8'($urandom);
         if ($urandom_range(0, 3) == 0) op[7:4] = 4'h0;
         send(op, $urandom_range(1, 3), $urandom_range(0, 3));
         send(8'($urandom_range(0, 9)), $urandom_range(1, 3), $urandom_range(0, 4));
         if ($urandom_range(0, 4) == 0)
            send(8'($urandom), $urandom_range(1, 2), 0);
      end
      settle();

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
